aes192_dec_ctrl: RTL and testbench

AES192_DEC_CTRL -- requirements
Module: aes192_dec_ctrl

---
 rtl/aes192_dec_ctrl.sv | 159 +++++++++++++++
 tb/tb_aes192_dec_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes192_dec_ctrl.sv
// AES-192 decryption controller: sequences an external key_expansion_192 block to
// build the full 52-word schedule, then drives an external inverse-round datapath.
module aes192_dec_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [191:0] key_in,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic [191:0] kx_key,
  output logic [31:0]  kx_rcon,
  input  logic [191:0] kx_next,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_mix,
  input  logic [127:0] dp_result,
  output logic         busy
);

  typedef enum logic [2:0] {
    NOKEY = 3'd0,
    KEXP  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [2:0]   k_reg;
  logic [3:0]   rc_reg;
  logic [127:0] state_reg;
  logic         out_valid_reg;
  logic [127:0] out_data_reg;
  logic [31:0]  w_reg [0:51];

  logic         key_acc;
  logic         blk_acc;
  logic         last_round;
  logic [5:0]   kx_base;
  logic [5:0]   rk_base;
  logic [127:0] k0;

  // Handshake qualifiers; a key offered in READY always beats a block.
  assign key_acc    = key_valid & key_ready;
  assign blk_acc    = in_valid & in_ready & ~key_valid;
  assign last_round = (fsm_reg == RUN) && (rc_reg == 4'd1);

  always_comb begin
    fsm_next  = fsm_reg;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (fsm_reg)
      NOKEY: begin
        key_ready = 1'b1;
        if (key_valid) fsm_next = KEXP;
      end
      KEXP: begin
        busy = 1'b1;
        if (k_reg == 3'd7) fsm_next = READY;
      end
      READY: begin
        key_ready = 1'b1;
        in_ready  = 1'b1;
        if (key_valid)     fsm_next = KEXP;
        else if (in_valid) fsm_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (rc_reg == 4'd1) fsm_next = DONE;
      end
      DONE: begin
        if (out_ready) fsm_next = READY;
      end
      default: fsm_next = NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= NOKEY;
      k_reg         <= 3'd0;
      rc_reg        <= 4'd0;
      state_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      fsm_reg <= fsm_next;

      if (key_acc)              k_reg <= 3'd0;
      else if (fsm_reg == KEXP) k_reg <= k_reg + 3'd1;

      if (blk_acc) begin
        state_reg <= in_data;
        rc_reg    <= 4'd12;
      end else if (fsm_reg == RUN) begin
        state_reg <= dp_result;
        rc_reg    <= rc_reg - 4'd1;
      end

      if (last_round) begin
        out_data_reg  <= dp_result ^ k0;
        out_valid_reg <= 1'b1;
      end else if ((fsm_reg == DONE) && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Step k reads W[6k..6k+5]; the base never exceeds 42, so reads stay in range.
  assign kx_base = {1'b0, k_reg, 2'b00} + {2'b00, k_reg, 1'b0};
  assign kx_rcon = 32'h0100_0000 << k_reg;

  // Clamp keeps dp_key defined even if rc were ever outside 0..12.
  assign rk_base = (rc_reg > 4'd12) ? 6'd0 : {rc_reg, 2'b00};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_kx_key
      assign kx_key[191-32*gi -: 32] = w_reg[kx_base + 6'(gi)];
    end

    for (gi = 0; gi < 4; gi++) begin : g_round_key
      assign dp_key[127-32*gi -: 32] = w_reg[rk_base + 6'(gi)];
      assign k0[127-32*gi -: 32]     = w_reg[gi];
    end

    for (gi = 0; gi < 52; gi++) begin : g_w
      if (gi < 6) begin : g_cipher_key
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       w_reg[gi] <= '0;
          else if (key_acc) w_reg[gi] <= key_in[191-32*gi -: 32];
        end
      end else begin : g_expanded
        // Word gi is produced by expansion step (gi-6)/6 in lane (gi-6)%6;
        // lanes that would land on W52/W53 simply do not exist.
        localparam int STEP = (gi - 6) / 6;
        localparam int LANE = (gi - 6) % 6;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            w_reg[gi] <= '0;
          else if ((fsm_reg == KEXP) && (k_reg == 3'(STEP)))
            w_reg[gi] <= kx_next[191-32*LANE -: 32];
        end
      end
    end
  endgenerate

  assign dp_state  = state_reg;
  assign dp_mix    = (rc_reg != 4'd12);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_aes192_dec_ctrl.sv
// Bench for aes192_dec_ctrl: models the external key-expansion and inverse-round
// blocks, and checks plaintexts against a textbook AES-192 inverse cipher.
module tb_aes192_dec_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [191:0] key_in = '0;
  logic         key_ready;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready = 1'b0;
  logic [191:0] kx_key;
  logic [31:0]  kx_rcon;
  logic [191:0] kx_next;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic         dp_mix;
  logic [127:0] dp_result;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];

  localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] PT_C2  = 128'h00112233445566778899aabbccddeeff;

  aes192_dec_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .kx_key(kx_key), .kx_rcon(kx_rcon), .kx_next(kx_next),
    .dp_state(dp_state), .dp_key(dp_key), .dp_mix(dp_mix), .dp_result(dp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- AES primitives ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[31-8*i -: 8] = sbox(w[31-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [191:0] kexp_step(input logic [191:0] k, input logic [31:0] rcon);
    logic [31:0] w [6];
    logic [31:0] t;
    logic [191:0] o;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    t = sub_word({w[5][23:0], w[5][31:24]}) ^ rcon;
    for (int i = 0; i < 6; i++) begin
      t = w[i] ^ t;
      o[191-32*i -: 32] = t;
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return o;
  endfunction

  // Textbook inverse cipher with its own key schedule.
  function automatic logic [127:0] ref_dec(input logic [191:0] key, input logic [127:0] ct);
    logic [31:0]  w [52];
    logic [31:0]  t;
    logic [127:0] s;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) t = sub_word({t[23:0], t[31:24]}) ^ (32'h0100_0000 << (i/6 - 1));
      w[i] = w[i-6] ^ t;
    end
    s = ct ^ {w[48], w[49], w[50], w[51]};
    for (int r = 11; r >= 1; r--) begin
      s = inv_sub(inv_shift(s));
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      s = inv_mix(s);
    end
    return inv_sub(inv_shift(s)) ^ {w[0], w[1], w[2], w[3]};
  endfunction

  // External blocks seen by the controller.
  assign kx_next   = kexp_step(kx_key, kx_rcon);
  assign dp_result = inv_sub(inv_shift(dp_mix ? inv_mix(dp_state ^ dp_key) : (dp_state ^ dp_key)));

  // ---------------- bench helpers ----------------
  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [191:0] key, input bit with_block);
    int n;
    n = 0;
    while (!key_ready && n < 100) begin step(); n++; end
    chk("key_ready_wait", key_ready, 1);
    key_valid = 1'b1;
    key_in    = key;
    if (with_block) begin
      in_valid = 1'b1;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    step();
    key_valid = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("kexp_busy", busy, 1);
      chk("kexp_rcon", kx_rcon, 32'h0100_0000 << i);
      chk("kexp_in_ready", in_ready, 0);
      if (i == 0) chk("kexp_kx_key0", kx_key, key);
      step();
    end
    chk("kexp_done_busy", busy, 0);
    chk("kexp_done_in_ready", in_ready, 1);
    $display("key loaded %h (with_block=%0d)", key, with_block);
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] exp, input bit poke_key);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = ct;
    exp_q.push_back(exp);
    step();
    in_valid = 1'b0;
    if (poke_key) begin
      key_valid = 1'b1;
      key_in    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("run_busy", busy, 1);
      if (poke_key) chk("run_key_ready", key_ready, 0);
      step();
      lat++;
    end
    key_valid = 1'b0;
    chk("latency", lat, 12);
    $display("block ct=%h latency=%0d", ct, lat);
  endtask

  task automatic take_output(input int hold);
    logic [127:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    step();
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_retain", out_data, exp);
    $display("output pt=%h expected=%h", out_data, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [191:0] key2;
    logic [127:0] ct;

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_key_ready", key_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    step();

    // FIPS-197 C.2 with a 20-cycle stalled sink.
    load_key(KEY_C2, 1'b0);
    send_block(CT_C2, PT_C2, 1'b0);
    take_output(20);

    // Back-to-back blocks under the same key.
    ct = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(ct, ref_dec(KEY_C2, ct), 1'b0);
    take_output(0);
    ct = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(ct, ref_dec(KEY_C2, ct), 1'b1);
    take_output(1);

    // Key and block offered together: key wins, block dropped.
    key2 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    load_key(key2, 1'b1);
    chk("collide_no_out", out_valid, 0);
    ct = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_block(ct, ref_dec(key2, ct), 1'b0);
    take_output(2);

    // Reset at RUN cycle 6 aborts the block and forgets the key.
    ct = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = 1'b1;
    in_data  = ct;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_key_ready", key_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("abort_idle_out_valid", out_valid, 0);
      chk("abort_idle_in_ready", in_ready, 0);
      step();
    end
    $display("reset abort checked");
    load_key(KEY_C2, 1'b0);
    send_block(CT_C2, PT_C2, 1'b0);
    take_output(1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected $finish");
    $fatal(1, "timeout");
  end

endmodule
